rr_sel_arbiter: RTL and testbench

- Four-requester round-robin arbiter that generates the 2-bit `sel` and `enable` pair consumed by `decoder_2to4`.
- The decoder turns its `sel`/`enable` into a one-hot grant; this block decides who owns the grant and for how long.
- It sits directly upstream of the decoder. Its outputs are registered so the decoder's one-hot output is glitch-free.

---
 rtl/rr_sel_arbiter_if.sv | 28 ++
 rtl/rr_sel_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_sel_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_sel_arbiter_if.sv
// Handshake bundle between the requesters and rr_sel_arbiter.
// The grant-release pulse is named rel because release is a reserved word.
interface rr_sel_arbiter_if;
  logic [3:0] req;
  logic       rel;
  logic [1:0] sel;
  logic       enable;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    input  rel,
    output sel,
    output enable,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output rel,
    input  sel,
    input  enable,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Four-requester round-robin arbiter producing registered sel/enable for decoder_2to4.
// Optional macro ARB_TIMEOUT_EN enables a hold counter that force-ends grants after HOLD_MAX cycles.
module rr_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_sel_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       enable_q, enable_d;
  logic       busy_q, busy_d;
  logic       hold_hit;
  logic       force_end;

  logic       found;
  logic [1:0] winner;
  logic [1:0] cand;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    cand   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    enable_d  = enable_q;
    force_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d    = winner;
          enable_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (bus.rel || !bus.req[sel_q] || hold_hit) begin
          enable_d  = 1'b0;
          ptr_d     = sel_q + 2'd1;
          state_d   = GAP;
          // A natural end in the same cycle wins over the forced one.
          force_end = hold_hit && !bus.rel && bus.req[sel_q];
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  assign hold_hit = (state_q == GRANT) && (hold_q == CNT_W'(HOLD_MAX - 1));

  // Cleared while idle so every grant starts counting from zero.
  always_comb begin
    hold_d    = hold_q;
    timeout_d = force_end;
    if (state_q == IDLE) begin
      hold_d = '0;
    end else if (state_q == GRANT && hold_q != '1) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_cfg;

  assign hold_hit    = 1'b0;
  assign unused_cfg  = force_end ^ ((HOLD_MAX + CNT_W) != 0);
  assign bus.timeout = 1'b0;
`endif

  assign bus.sel    = sel_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Self-checking bench for rr_sel_arbiter; expected grant owners are queued
// when stimulus is applied and popped when enable rises.
module tb_rr_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  rr_sel_arbiter_if bus ();

  rr_sel_arbiter #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_release;
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0;
  endtask

  // Advance until enable rises, bounded; reports how many low cycles were seen.
  task automatic wait_grant(output logic ok, output int lows);
    ok   = 1'b0;
    lows = 0;
    for (int n = 0; n < 16; n++) begin
      if (bus.enable === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lows++;
      tick();
    end
  endtask

  task automatic test_reset;
    logic [1:0] exp;
    bus.req = 4'b1111;
    bus.rel = 1'b0;
    rst_n   = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.sel !== 2'b00 || bus.enable !== 1'b0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state sel=%b en=%b busy=%b to=%b required 00 0 0 0",
               bus.sel, bus.enable, bus.busy, bus.timeout);
    end
    rst_n = 1'b1;
    sb.push_back(2'b00);
    tick();
    exp = sb.pop_front();
    checks++;
    if (bus.enable !== 1'b1 || bus.sel !== exp || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant en=%b sel=%b busy=%b required 1 %b 1",
               bus.enable, bus.sel, bus.busy, exp);
    end
  endtask

  task automatic test_rotation;
    logic ok;
    int lows;
    logic [1:0] exp;
    sb.push_back(2'b01); sb.push_back(2'b10); sb.push_back(2'b11); sb.push_back(2'b00);
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      checks++;
      if (bus.enable !== 1'b1) begin
        errors++;
        $display("FAIL rot_hold[%0d] en=%b required 1", k, bus.enable);
      end
      pulse_release();
      checks++;
      if (bus.enable !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL rot_gap[%0d] en=%b busy=%b required 0 1", k, bus.enable, bus.busy);
      end
      wait_grant(ok, lows);
      checks++;
      if (!ok || sb.size() == 0) begin
        errors++;
        $display("FAIL rot_grant[%0d] no grant within bound (ok=%b) required grant", k, ok);
      end else begin
        exp = sb.pop_front();
        if (bus.sel !== exp || lows != 2) begin
          errors++;
          $display("FAIL rot_grant[%0d] sel=%b lows=%0d required %b 2", k, bus.sel, lows, exp);
        end
      end
    end
  endtask

  task automatic test_skip_wrap;
    logic ok;
    int lows;
    logic [1:0] exp;
    bus.req = 4'b0100;
    sb.push_back(2'b10);
    tick();
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL skip_to_10 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL skip_to_10 sel=%b required %b", bus.sel, exp);
      end
    end
    bus.req = 4'b0101;
    sb.push_back(2'b00);
    tick();
    pulse_release();
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL wrap_to_00 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL wrap_to_00 sel=%b required %b", bus.sel, exp);
      end
    end
    sb.push_back(2'b10);
    tick();
    pulse_release();
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL wrap_next_10 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL wrap_next_10 sel=%b required %b", bus.sel, exp);
      end
    end
  endtask

  task automatic test_withdraw;
    logic ok;
    int lows;
    logic [1:0] exp;
    bus.req = 4'b0010;
    sb.push_back(2'b01);
    tick();
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL wd_grant_01 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL wd_grant_01 sel=%b required %b", bus.sel, exp);
      end
    end
    tick();
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.enable !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_gap en=%b busy=%b required 0 1", bus.enable, bus.busy);
    end
    tick();
    checks++;
    if (bus.enable !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 2'b01) begin
      errors++;
      $display("FAIL wd_idle en=%b busy=%b sel=%b required 0 0 01", bus.enable, bus.busy, bus.sel);
    end
    bus.req = 4'b1111;
    sb.push_back(2'b10);
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL wd_ptr_10 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp || lows != 1) begin
        errors++;
        $display("FAIL wd_ptr_10 sel=%b lows=%0d required %b 1", bus.sel, lows, exp);
      end
    end
  endtask

  task automatic test_timeout;
    logic ok;
    int lows;
    int hi;
    logic to_seen;
    logic [1:0] exp;
    bus.req = 4'b0010;
    sb.push_back(2'b01);
    tick();
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL to_grant_01 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL to_grant_01 sel=%b required %b", bus.sel, exp);
      end
    end
    hi = 1;
    to_seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.enable !== 1'b1) break;
      hi++;
      if (bus.timeout !== 1'b0) to_seen = 1'b1;
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (hi != 4 || to_seen !== 1'b0) begin
      errors++;
      $display("FAIL to_hold_len high=%0d early_to=%b required 4 0", hi, to_seen);
    end
    checks++;
    if (bus.timeout !== 1'b1 || bus.busy !== 1'b1 || bus.enable !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse to=%b busy=%b en=%b required 1 1 0", bus.timeout, bus.busy, bus.enable);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_one_cycle to=%b required 0", bus.timeout);
    end
    sb.push_back(2'b01);
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL to_regrant no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL to_regrant sel=%b required %b", bus.sel, exp);
      end
    end
    tick(); tick(); tick();
    pulse_release();
    checks++;
    if (bus.enable !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_rel_coincide en=%b to=%b required 0 0", bus.enable, bus.timeout);
    end
    sb.push_back(2'b01);
    wait_grant(ok, lows);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++;
      $display("FAIL to_regrant2 no grant (ok=%b) required grant", ok);
    end else begin
      exp = sb.pop_front();
      if (bus.sel !== exp) begin
        errors++;
        $display("FAIL to_regrant2 sel=%b required %b", bus.sel, exp);
      end
    end
`else
    checks++;
    if (hi != 31 || to_seen !== 1'b0 || bus.enable !== 1'b1) begin
      errors++;
      $display("FAIL no_to_hold high=%0d to_seen=%b en=%b required 31 0 1", hi, to_seen, bus.enable);
    end
`endif
  endtask

  task automatic test_reset_mid_grant;
    logic [1:0] exp;
    checks++;
    if (bus.enable !== 1'b1) begin
      errors++;
      $display("FAIL rmg_pre en=%b required 1", bus.enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.enable !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 2'b00) begin
      errors++;
      $display("FAIL rmg_async en=%b busy=%b sel=%b required 0 0 00", bus.enable, bus.busy, bus.sel);
    end
    #2;
    rst_n = 1'b1;
    bus.req = 4'b1010;
    sb.push_back(2'b01);
    tick();
    exp = sb.pop_front();
    checks++;
    if (bus.enable !== 1'b1 || bus.sel !== exp) begin
      errors++;
      $display("FAIL rmg_restart en=%b sel=%b required 1 %b", bus.enable, bus.sel, exp);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.rel = 1'b0;
    test_reset();
    test_rotation();
    test_skip_wrap();
    test_withdraw();
    test_timeout();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
